data_ram: RTL and testbench
===========================

Name: data_ram

Overview:
- Byte-addressable, single-port synchronous data memory. Successor to the word-only `ram`.
- Adds byte/half/word accesses, sign/zero extension of loads, misalignment detection, and a configurable read latency.
- Uses a fixed-latency req/rvalid handshake.
- Sits between the load/store unit and the memory array of the RISC-V core.

Parameters:
- XLen, 32, data width in bits. Fixed at 32: word access needs 4 byte lanes.
- NPos, 128, depth in XLen-bit words. Must be a power of 2.
- RdLatency, 1, cycles from accepted request to rvalid_o. Legal range 1..4.
- AWidth, $clog2(NPos*XLen/8), byte-address width. Derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  access request. Accepted when req_i & ready_o.
- we_i  in  1  1 = store, 0 = load.
- a_i  in  AWidth  byte address.
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- unsigned_i  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- wd_i  in  XLen  store data, right-aligned (lane 0 holds the LSBs).
- ready_o  out  1  block can accept a request.
- rvalid_o  out  1  response valid. Exactly RdLatency cycles after acceptance.
- rd_o  out  XLen  load data, extended. 0 for stores and errors.
- err_o  out  1  access error. Qualified by rvalid_o.

Behaviour:
- Address decode:
  - Word index = a_i[AWidth-1:2]; byte offset = a_i[1:0].
- Errors:
  - Conditions: size 11; half with a_i[0]=1; word with a_i[1:0]!=0.
  - An errored access never writes memory.
  - Its response carries err_o=1, rd_o=0.
- Stores:
  - Byte enables: byte 0001<<off, half 0011<<off, word 1111.
  - Lane data = wd_i shifted left by 8*off.
  - Only enabled bytes are written, at the accepting clock edge.
  - A store still produces a response (rvalid_o=1, rd_o=0, err_o=0) so the handshake is uniform.
- Loads:
  - The array read is registered at the accepting edge.
  - Further pipeline stages (RdLatency-1) carry data, offset, size, unsigned, we and err.
  - In the final stage: shift right by 8*off, mask to size, then sign- or zero-extend.
- Throughput and ordering:
  - One request per cycle, no stalls once ready_o=1.
  - Responses are strictly in order.
  - rvalid_o is a 1-cycle pulse per request.
- Hazards:
  - Store at edge k, load to same word at edge k+1 returns the new data.
  - There is no same-cycle hazard (single port).
- Reset (asynchronous):
  - rvalid_o=0, err_o=0, rd_o=0, all pipeline valids cleared.
  - In-flight responses are dropped.
  - Memory contents are untouched unless DATA_RAM_ZERO_INIT_EN is defined.
- ready_o without the macro: 0 while rst_ni=0, 1 from the first edge after release.
- Requests with ready_o=0 are ignored: no write, no response.

Optional Feature:
- Macro DATA_RAM_ZERO_INIT_EN.
- When defined, an FSM is added with states INIT and RUN.
- INIT:
  - Entered on reset.
  - A clear counter starts at 0 and writes 0 to word[cnt] each cycle, for NPos cycles.
  - ready_o=0 throughout.
- RUN:
  - Entered after the write of word[NPos-1].
  - ready_o=1 from then on.
- Reset asserted mid-INIT restarts the clear at word 0.
- When undefined:
  - No FSM and no counter.
  - Memory is uninitialised (X in simulation).
  - ready_o behaves as described in Behaviour.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x010, word load @0x010 -> rvalid_o exactly RdLatency cycles later, rd_o=0xDEADBEEF, err_o=0.
- Byte stores 0x80 @0x021 and half 0x1234 @0x022 over a word of 0; signed byte load @0x021 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @0x020 -> 0x12348000.
- Half load @0x023, word load @0x022, size 11 load @0x000 -> each err_o=1, rd_o=0; word store size 11 @0x000 -> memory unchanged on readback.
- Back-to-back: store 0xA5A5A5A5 @0x040 at edge k, load @0x040 at edge k+1 -> 0xA5A5A5A5. 128 consecutive word loads -> 128 in-order rvalid_o pulses, no gaps. Repeat for RdLatency=1 and 4.
- Assert rst_ni low with 2 loads in flight -> no rvalid_o after reset, outputs 0; memory retains prior data.
- DATA_RAM_ZERO_INIT_EN:
  - ready_o=0 for exactly 128 cycles after reset release.
  - Then a word load @0x1FC -> 0.
  - Reset at clear cycle 50 -> clear restarts, ready_o low for a further 128 cycles.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: byte-addressable single-port data memory, fixed-latency req/rvalid.
// Ports: clk_i, rst_ni, req_i, we_i, a_i, size_i, unsigned_i, wd_i -> ready_o, rvalid_o, rd_o, err_o.
// Optional macro DATA_RAM_ZERO_INIT_EN: clears all words after reset (INIT/RUN FSM).
module data_ram #(
  parameter int XLen      = 32,
  parameter int NPos      = 128,
  parameter int RdLatency = 1,
  parameter int AWidth    = $clog2(NPos*XLen/8)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [AWidth-1:0] a_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLen-1:0]   wd_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [XLen-1:0]   rd_o,
  output logic              err_o
);

  localparam int IW = $clog2(NPos);

  typedef struct packed {
    logic            v;
    logic            we;
    logic            err;
    logic            uns;
    logic [1:0]      size;
    logic [1:0]      off;
    logic [XLen-1:0] data;
  } stg_t;

  logic [XLen-1:0] mem [NPos];
  stg_t            pipe [RdLatency];
  stg_t            last;

  logic            rdy;
  logic            acc;
  logic            err;
  logic            wr;
  logic [3:0]      be;
  logic [IW-1:0]   idx;
  logic [1:0]      off;
  logic [XLen-1:0] wl;
  logic [XLen-1:0] sh;
  logic [XLen-1:0] ext;

  assign idx = a_i[AWidth-1:2];
  assign off = a_i[1:0];
  assign acc = req_i & rdy;

  always_comb begin
    err = 1'b1;
    be  = 4'b0000;
    unique case (size_i)
      2'b00: begin
        err = 1'b0;
        be  = 4'b0001 << off;
      end
      2'b01: begin
        err = off[0];
        be  = 4'b0011 << off;
      end
      2'b10: begin
        err = |off;
        be  = 4'b1111;
      end
      default: begin
        err = 1'b1;
        be  = 4'b0000;
      end
    endcase
  end

  assign wr = acc & we_i & ~err;
  assign wl = wd_i << {off, 3'b000};

`ifdef DATA_RAM_ZERO_INIT_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [IW-1:0] cnt;

  // ready_o rises together with the move to RUN, after the last word is cleared
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= INIT;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(NPos-1)) begin
            state <= RUN;
            rdy   <= 1'b1;
          end
        end
        RUN: rdy <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr && be[b]) mem[idx][8*b +: 8] <= wl[8*b +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy <= 1'b0;
    else         rdy <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr && be[b]) mem[idx][8*b +: 8] <= wl[8*b +: 8];
    end
  end
`endif

  // Stage 0 samples the array before this edge's write lands, which is
  // harmless: a single port never loads and stores in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RdLatency; i++) pipe[i] <= '0;
    end else begin
      pipe[0].v    <= acc;
      pipe[0].we   <= we_i;
      pipe[0].err  <= err;
      pipe[0].uns  <= unsigned_i;
      pipe[0].size <= size_i;
      pipe[0].off  <= off;
      pipe[0].data <= mem[idx];
      for (int i = 1; i < RdLatency; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[RdLatency-1];
  assign sh   = last.data >> {last.off, 3'b000};

  always_comb begin
    ext = sh;
    unique case (last.size)
      2'b00: begin
        if (last.uns) ext = {{(XLen-8){1'b0}}, sh[7:0]};
        else          ext = {{(XLen-8){sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        if (last.uns) ext = {{(XLen-16){1'b0}}, sh[15:0]};
        else          ext = {{(XLen-16){sh[15]}}, sh[15:0]};
      end
      default: ext = sh;
    endcase
  end

  assign ready_o  = rdy;
  assign rvalid_o = last.v;
  assign err_o    = last.v & last.err;
  assign rd_o     = (last.v & ~last.we & ~last.err) ? ext : '0;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: scoreboard bench for data_ram at RdLatency 1 and 4.
// Byte-array reference model; monitors pop expectations on rvalid_o.
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req;
  logic        we;
  logic        uns;
  logic [8:0]  a;
  logic [1:0]  size;
  logic [31:0] wd;

  logic        rdy1, rv1, er1;
  logic [31:0] rd1;
  logic        rdy4, rv4, er4;
  logic [31:0] rd4;

  always #5 clk = ~clk;

  data_ram #(.RdLatency(1)) u1 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we),
    .a_i(a), .size_i(size), .unsigned_i(uns), .wd_i(wd),
    .ready_o(rdy1), .rvalid_o(rv1), .rd_o(rd1), .err_o(er1)
  );

  data_ram #(.RdLatency(4)) u4 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we),
    .a_i(a), .size_i(size), .unsigned_i(uns), .wd_i(wd),
    .ready_o(rdy4), .rvalid_o(rv4), .rd_o(rd4), .err_o(er4)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       q1[$];
  exp_t       q4[$];
  logic [7:0] mem_m [512];
  int         cyc  = 0;
  int         nchk = 0;
  int         nerr = 0;

`ifdef DATA_RAM_ZERO_INIT_EN
  localparam int RdyLat = 128;
`else
  localparam int RdyLat = 1;
`endif

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Reference: memory as 512 bytes; loads assemble n bytes little-endian
  // and sign-extend by subtracting 2^(8n) when the top bit is set.
  function automatic exp_t model(input logic w, input logic [8:0] ad,
                                 input logic [1:0] sz, input logic u,
                                 input logic [31:0] d);
    exp_t        e;
    int          n;
    logic [31:0] v;
    logic        bad;
    n   = 1 << sz;
    bad = (sz == 2'd3) || (sz == 2'd1 && ad[0]) ||
          (sz == 2'd2 && ad[1:0] != 2'd0);
    e.rd  = '0;
    e.err = bad;
    e.cyc = 0;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < n; i++) mem_m[int'(ad)+i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mem_m[int'(ad)+i]) << (8*i));
        if (!u && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
        e.rd = v;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic w, input logic [8:0] ad,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] d);
    exp_t e;
    req = 1'b1; we = w; a = ad; size = sz; uns = u; wd = d;
    check("ready before issue", {30'b0, rdy1, rdy4}, 32'd3);
    @(posedge clk); #1;
    e = model(w, ad, sz, u, d);
    e.cyc = cyc - 1;
    q1.push_back(e);
    q4.push_back(e);
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    int n;
    n = 0;
    rst_ni = 1'b0;
    req = 1'b0;
    q1.delete();
    q4.delete();
    @(posedge clk); #1;
    check("rst u1 rdy/rv/err", {29'b0, rdy1, rv1, er1}, 32'd0);
    check("rst u1 rd", rd1, 32'd0);
    check("rst u4 rdy/rv/err", {29'b0, rdy4, rv4, er4}, 32'd0);
    check("rst u4 rd", rd4, 32'd0);
`ifdef DATA_RAM_ZERO_INIT_EN
    foreach (mem_m[i]) mem_m[i] = 8'h00;
`endif
    @(negedge clk);
    rst_ni = 1'b1;
    while (rdy1 !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready cycles after release", n, RdyLat);
    check("u4 ready", {31'b0, rdy4}, 32'd1);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rv1 !== 1'b0) begin
      if (q1.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL u1 unexpected rvalid: rd %h", rd1);
      end else begin
        e = q1.pop_front();
        check("u1 rd", rd1, e.rd);
        check("u1 err", {31'b0, er1}, {31'b0, e.err});
        check("u1 latency", cyc - e.cyc, 32'd1);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rv4 !== 1'b0) begin
      if (q4.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL u4 unexpected rvalid: rd %h", rd4);
      end else begin
        e = q4.pop_front();
        check("u4 rd", rd4, e.rd);
        check("u4 err", {31'b0, er4}, {31'b0, e.err});
        check("u4 latency", cyc - e.cyc, 32'd4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req = 1'b0; we = 1'b0; uns = 1'b0;
    a = '0; size = '0; wd = '0;
    foreach (mem_m[i]) mem_m[i] = 8'hxx;
    do_reset();

`ifdef DATA_RAM_ZERO_INIT_EN
    issue(0, 9'h1FC, 2'd2, 0, 0);
    idle(6);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("ready low mid-init", {31'b0, rdy1}, 32'd0);
    do_reset();
`endif

    for (int w = 0; w < 128; w++) issue(1, 9'(w*4), 2'd2, 0, $urandom);

    issue(1, 9'h010, 2'd2, 0, 32'hDEADBEEF);
    issue(0, 9'h010, 2'd2, 0, 0);
    idle(2);

    issue(1, 9'h020, 2'd2, 0, 32'h0);
    issue(1, 9'h021, 2'd0, 0, 32'h80);
    issue(1, 9'h022, 2'd1, 0, 32'h1234);
    issue(0, 9'h021, 2'd0, 0, 0);
    issue(0, 9'h021, 2'd0, 1, 0);
    issue(0, 9'h020, 2'd2, 0, 0);

    issue(0, 9'h023, 2'd1, 0, 0);
    issue(0, 9'h022, 2'd2, 0, 0);
    issue(0, 9'h000, 2'd3, 0, 0);
    issue(1, 9'h000, 2'd3, 0, 32'hFFFFFFFF);
    issue(0, 9'h000, 2'd2, 0, 0);

    issue(1, 9'h040, 2'd2, 0, 32'hA5A5A5A5);
    issue(0, 9'h040, 2'd2, 0, 0);

    for (int w = 0; w < 128; w++) issue(0, 9'(w*4), 2'd2, 0, 0);
    idle(6);

    issue(0, 9'h010, 2'd2, 0, 0);
    issue(0, 9'h040, 2'd2, 0, 0);
    do_reset();
    issue(0, 9'h010, 2'd2, 0, 0);
    issue(0, 9'h040, 2'd2, 0, 0);
    issue(0, 9'h020, 2'd2, 0, 0);
    idle(2);

    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    idle(8);
    check("queues drained", q1.size() + q4.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
